// File: rtl/display_pkg.sv
// Shared timing defaults, state encoding and pixel lane layout for the
// display scanout path.
package display_pkg;

  localparam int DEF_ADDR_W   = 20;
  localparam int DEF_H_ACTIVE = 10;
  localparam int DEF_H_FP     = 2;
  localparam int DEF_H_SYNC   = 3;
  localparam int DEF_H_BP     = 1;
  localparam int DEF_V_ACTIVE = 10;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 1;

  // Buffer word layout: r in the low byte, b in the high byte.
  localparam int PIX_W      = 24;
  localparam int LANE_W     = 8;
  localparam int LANE_R_LSB = 0;
  localparam int LANE_G_LSB = 8;
  localparam int LANE_B_LSB = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } scan_state_e;

  function automatic int calc_h_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int calc_v_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_timer.sv
// Horizontal/vertical position counters with active-region decode, sync
// levels and frame start/end strobes; everything is idle-gated by run.
module raster_timer
  import display_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic sof,
  output logic eof
);

  localparam int H_TOTAL = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  int unsigned   h_pos;
  int unsigned   v_pos;
  logic          h_last;
  logic          v_last;
  logic          in_hs;
  logic          in_vs;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Widen to 32 bits so a sync window ending exactly at the total still compares.
  assign h_pos = 32'(h_cnt);
  assign v_pos = 32'(v_cnt);

  assign in_hs  = (h_pos >= HS_START) && (h_pos < HS_END);
  assign in_vs  = (v_pos >= VS_START) && (v_pos < VS_END);

  assign active = run && (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
  assign hsync  = (run && in_hs) ? SYNC_POL : ~SYNC_POL;
  assign vsync  = (run && in_vs) ? SYNC_POL : ~SYNC_POL;
  assign sof    = run && (h_cnt == '0) && (v_cnt == '0);
  assign eof    = run && h_last && v_last;

endmodule

// File: rtl/buf_scanout.sv
// Read side of the ping-pong pixel buffers: run/idle control, frame-boundary
// buffer swap, linear read addressing and one-clock output alignment.
module buf_scanout
  import display_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              active_buf,
  output logic [ADDR_W-1:0] addr_read0,
  output logic              RE0,
  output logic [ADDR_W-1:0] addr_read1,
  output logic              RE1,
  input  logic [7:0]        dataout00,
  input  logic [7:0]        dataout01,
  input  logic [7:0]        dataout02,
  input  logic [7:0]        dataout10,
  input  logic [7:0]        dataout11,
  input  logic [7:0]        dataout12,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  scan_state_e state_q;
  scan_state_e state_d;
  logic        swap_take;
  logic        run;

  logic        active;
  logic        hsync_raw;
  logic        vsync_raw;
  logic        sof;
  logic        eof;

  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] addr0_q;
  logic [ADDR_W-1:0] addr1_q;
  logic              rd0;
  logic              rd1;

  logic             de_q;
  logic             hs_q;
  logic             vs_q;
  logic             fs_q;
  logic             sel_q;
  logic [PIX_W-1:0] word0;
  logic [PIX_W-1:0] word1;
  logic [PIX_W-1:0] word_sel;

  assign run = (state_q == RUN);

  raster_timer #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (run),
    .active  (active),
    .hsync   (hsync_raw),
    .vsync   (vsync_raw),
    .sof     (sof),
    .eof     (eof)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Enable and swap_req only matter at a frame boundary: the last clock of a
  // running frame, or the clock that leaves IDLE.
  // NOTE: every output of this block gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    swap_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = RUN;
          swap_take = swap_req;
        end
      end
      RUN: begin
        if (eof) begin
          if (!enable) state_d = IDLE;
          swap_take = swap_req;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_buf <= 1'b0;
      swap_ack   <= 1'b0;
    end else begin
      swap_ack <= swap_take;
      if (swap_take) active_buf <= ~active_buf;
    end
  end

  assign rd0 = active && !active_buf;
  assign rd1 = active &&  active_buf;

  // Row-major order makes the address a plain counter; it restarts each frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
    end else begin
      if (!run || eof)  rd_addr <= '0;
      else if (active)  rd_addr <= rd_addr + ADDR_W'(1);
      if (rd0) addr0_q <= rd_addr;
      if (rd1) addr1_q <= rd_addr;
    end
  end

  assign RE0        = rd0;
  assign RE1        = rd1;
  assign addr_read0 = rd0 ? rd_addr : addr0_q;
  assign addr_read1 = rd1 ? rd_addr : addr1_q;

  // The buffers return data one clock after RE, so timing and the buffer
  // select are delayed by the same clock to meet their data at the pins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      de_q  <= 1'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      fs_q  <= 1'b0;
      sel_q <= 1'b0;
    end else begin
      de_q  <= active;
      hs_q  <= hsync_raw;
      vs_q  <= vsync_raw;
      fs_q  <= sof;
      sel_q <= active_buf;
    end
  end

  assign word0    = {dataout02, dataout01, dataout00};
  assign word1    = {dataout12, dataout11, dataout10};
  assign word_sel = sel_q ? word1 : word0;

  assign pix_r       = de_q ? word_sel[LANE_R_LSB +: LANE_W] : '0;
  assign pix_g       = de_q ? word_sel[LANE_G_LSB +: LANE_W] : '0;
  assign pix_b       = de_q ? word_sel[LANE_B_LSB +: LANE_W] : '0;
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;

endmodule
